// File: rtl/interval_meter.sv
// Interval meter: counts prescaled ticks between start and stop and holds the result under a valid/ack handshake.
// Optional abort input enabled by defining INTERVAL_METER_ABORT_EN.
module interval_meter #(
  parameter int WIDTH    = 12,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
`ifdef INTERVAL_METER_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    psc, psc_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic             abort_i;

`ifdef INTERVAL_METER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    psc_nx   = psc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          psc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      RUN: begin
        // The stop edge's tick is part of the measurement, so the update precedes the latch.
        if (psc == PW'(PRESCALE - 1)) begin
          psc_nx = '0;
          if (&cnt) ovf_nx = 1'b1;
          else      cnt_nx = cnt + 1'b1;
        end else begin
          psc_nx = psc + 1'b1;
        end
        if (abort_i)   state_nx = IDLE;
        else if (stop) state_nx = DONE;
      end
      DONE: begin
        if (abort_i || ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      psc   <= psc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
      valid <= (state_nx == DONE);
      busy  <= (state_nx == RUN);
      if (state == RUN && state_nx == DONE) begin
        count    <= cnt_nx;
        overflow <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_interval_meter.sv
// Directed scoreboard bench for interval_meter across three parameterisations
// (W12/P1, W12/P4, W4/P1); abort scenarios run when INTERVAL_METER_ABORT_EN is defined.
module tb_interval_meter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  start_v = '0, stop_v = '0, ack_v = '0, abort_v = '0;
  logic [11:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  logic [2:0]  valid_v, ovf_v, busy_v;
  int          compared = 0;
  int          mismatched = 0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  interval_meter #(.WIDTH(12), .PRESCALE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]), .ack(ack_v[0]),
`ifdef INTERVAL_METER_ABORT_EN
    .abort(abort_v[0]),
`endif
    .count(cnt0), .valid(valid_v[0]), .overflow(ovf_v[0]), .busy(busy_v[0]));

  interval_meter #(.WIDTH(12), .PRESCALE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]), .ack(ack_v[1]),
`ifdef INTERVAL_METER_ABORT_EN
    .abort(abort_v[1]),
`endif
    .count(cnt1), .valid(valid_v[1]), .overflow(ovf_v[1]), .busy(busy_v[1]));

  interval_meter #(.WIDTH(4), .PRESCALE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]), .ack(ack_v[2]),
`ifdef INTERVAL_METER_ABORT_EN
    .abort(abort_v[2]),
`endif
    .count(cnt2), .valid(valid_v[2]), .overflow(ovf_v[2]), .busy(busy_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] count_of(input int d);
    case (d)
      0:       return cnt0;
      1:       return cnt1;
      default: return {8'h00, cnt2};
    endcase
  endfunction

  // Start at E0, stop sampled at E0+n; expected result pushed when stimulus is driven.
  task automatic measure(input int d, input int n, input logic [11:0] ec, input logic eo);
    int          waited;
    logic [12:0] e;
    exp_q.push_back({eo, ec});
    @(negedge clk); start_v[d] = 1'b1;
    @(negedge clk); start_v[d] = 1'b0;
    chk("busy_in_run", busy_v[d], 1'b1);
    repeat (n - 1) @(negedge clk);
    stop_v[d] = 1'b1;
    @(negedge clk); stop_v[d] = 1'b0;
    waited = 0;
    while (!valid_v[d] && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("valid_latency", waited, 0);
    e = exp_q.pop_front();
    chk("count", count_of(d), e[11:0]);
    chk("overflow", ovf_v[d], e[12]);
    chk("busy_in_done", busy_v[d], 1'b0);
  endtask

  task automatic do_ack(input int d);
    ack_v[d] = 1'b1;
    @(negedge clk); ack_v[d] = 1'b0;
    chk("valid_after_ack", valid_v[d], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid_v, 3'b000);
    chk("rst_busy", busy_v, 3'b000);
    chk("rst_count0", cnt0, 12'd0);
    chk("rst_ovf", ovf_v, 3'b000);
    @(negedge clk); rst_n = 1'b1;

    measure(0, 37, 12'd37, 1'b0);
    do_ack(0);

    measure(1, 10, 12'd2, 1'b0);
    do_ack(1);
    measure(1, 12, 12'd3, 1'b0);
    do_ack(1);
    measure(1, 3, 12'd0, 1'b0);
    do_ack(1);

    measure(2, 20, 12'd15, 1'b1);
    do_ack(2);
    measure(2, 3, 12'd3, 1'b0);
    do_ack(2);
    measure(2, 15, 12'd15, 1'b0);
    do_ack(2);

    // start and stop together in IDLE, stop held: one RUN edge then DONE with count 1
    @(negedge clk); start_v[0] = 1'b1; stop_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    chk("ss_busy", busy_v[0], 1'b1);
    chk("ss_valid_early", valid_v[0], 1'b0);
    @(negedge clk); stop_v[0] = 1'b0;
    chk("ss_valid", valid_v[0], 1'b1);
    chk("ss_count", cnt0, 12'd1);
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; stop_v[0] = 1'b1;
    @(negedge clk); stop_v[0] = 1'b0;
    chk("done_hold_valid", valid_v[0], 1'b1);
    chk("done_hold_count", cnt0, 12'd1);
    chk("done_hold_busy", busy_v[0], 1'b0);
    start_v[0] = 1'b1; ack_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; ack_v[0] = 1'b0;
    chk("ack_start_valid", valid_v[0], 1'b0);
    chk("ack_start_busy", busy_v[0], 1'b0);
    chk("count_held_idle", cnt0, 12'd1);

`ifdef INTERVAL_METER_ABORT_EN
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk); abort_v[0] = 1'b0;
    chk("abort_run_busy", busy_v[0], 1'b0);
    stop_v[0] = 1'b1;
    @(negedge clk); stop_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_run_valid", valid_v[0], 1'b0);
    chk("abort_run_count", cnt0, 12'd1);
    measure(0, 7, 12'd7, 1'b0);
    abort_v[0] = 1'b1;
    @(negedge clk); abort_v[0] = 1'b0;
    chk("abort_done_valid", valid_v[0], 1'b0);
    chk("abort_done_count", cnt0, 12'd7);
`endif

    // asynchronous reset in the middle of a RUN
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_v[0], 1'b0);
    chk("arst_valid", valid_v, 3'b000);
    chk("arst_count0", cnt0, 12'd0);
    chk("arst_count2", cnt2, 4'd0);
    chk("arst_ovf", ovf_v, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    stop_v[0] = 1'b1;
    @(negedge clk); stop_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_valid", valid_v[0], 1'b0);
    chk("arst_no_busy", busy_v[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
